alu_ctrl_unit: RTL and testbench

Sequencing control unit that sits directly upstream of the ALU. It accepts one 32-bit instruction at a time over a valid/ready handshake and reads operands from an internal 16×32 register file. It drives the ALU operand, opcode and carry-in lines, then captures the ALU result and flags. It writes the result back to the register file and the flags to a C/Z/N status register.

---
 rtl/alu_cu_pkg.sv | 41 ++++
 rtl/cu_reg_file.sv | 37 +++
 rtl/alu_ctrl_unit.sv | 134 +++++++++++++
 tb/tb_alu_ctrl_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cu_pkg.sv
// Shared definitions for the ALU sequencing control unit:
// opcodes, instruction field positions, FSM states and flag indices.
package alu_cu_pkg;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_LDI = 6'b000001;
  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_EQ  = 6'b100000;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_LO  = 22;
  localparam int RS1_LO = 18;
  localparam int RS2_LO = 14;
  localparam int UC_BIT = 13;
  localparam int IMM_HI = 17;
  localparam int IMM_W  = IMM_HI + 1;

  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_e;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_NOP) || (op == OP_LDI) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_EQ);
  endfunction

  function automatic logic op_writes(input logic [5:0] op);
    return (op == OP_LDI) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_EQ);
  endfunction

endpackage

// File: rtl/cu_reg_file.sv
// Register file: two read ports, a debug read port, one write port.
// Entry 0 reads as zero and ignores writes.
module cu_reg_file
  import alu_cu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] ra_addr_i,
  output logic [31:0]              ra_data_o,
  input  logic [$clog2(NREGS)-1:0] rb_addr_i,
  output logic [31:0]              rb_data_o,
  input  logic [$clog2(NREGS)-1:0] dbg_addr_i,
  output logic [31:0]              dbg_data_o,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [31:0]              wdata_i
);

  logic [31:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o  = (ra_addr_i == '0) ? '0 : mem_q[ra_addr_i];
  assign rb_data_o  = (rb_addr_i == '0) ? '0 : mem_q[rb_addr_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_ctrl_unit.sv
// Four-phase issue sequencer in front of an external ALU.
// Define CU_CARRY_CHAIN_EN to feed the C flag into ADD/SUB carry-in.
module alu_ctrl_unit
  import alu_cu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [31:0]              instr,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [5:0]               alu_op,
  output logic                     alu_cin,
  input  logic [31:0]              alu_ans,
  input  logic                     alu_cout,
  input  logic                     alu_z,
  input  logic                     alu_n,
  output logic [2:0]               flags,
  output logic                     done,
  output logic                     illegal,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [31:0]              dbg_data
);

  localparam int AW = $clog2(NREGS);

  state_e      state_q;
  logic [31:0] instr_q;

  logic [5:0]    op;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [31:0]   rs1_data;
  logic [31:0]   rs2_data;
  logic          we;
  logic [31:0]   wdata;
  logic          cin_d;

  assign op  = instr_q[OP_HI:OP_LO];
  assign rd  = instr_q[RD_LO +: AW];
  assign rs1 = instr_q[RS1_LO +: AW];
  assign rs2 = instr_q[RS2_LO +: AW];

  assign instr_ready = (state_q == ST_IDLE);

  assign we    = (state_q == ST_WB) && op_writes(op);
  assign wdata = (op == OP_LDI)
               ? {{(32-IMM_W){1'b0}}, instr_q[IMM_HI:0]}
               : alu_ans;

`ifdef CU_CARRY_CHAIN_EN
  assign cin_d = ((op == OP_ADD) || (op == OP_SUB)) &&
                 instr_q[UC_BIT] && flags[FLAG_C];
`else
  assign cin_d = 1'b0;
`endif

  cu_reg_file #(
    .NREGS(NREGS)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr_i (rs1),
    .ra_data_o (rs1_data),
    .rb_addr_i (rs2),
    .rb_data_o (rs2_data),
    .dbg_addr_i(dbg_addr),
    .dbg_data_o(dbg_data),
    .we_i      (we),
    .waddr_i   (rd),
    .wdata_i   (wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      alu_cin <= 1'b0;
      flags   <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            // Flag the reject on entry so the pulse lands in DECODE.
            illegal <= !op_legal(instr[OP_HI:OP_LO]);
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!op_legal(op)) begin
            state_q <= ST_IDLE;
          end else begin
            alu_a   <= rs1_data;
            alu_b   <= rs2_data;
            alu_op  <= op;
            alu_cin <= cin_d;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          done    <= 1'b1;
          state_q <= ST_WB;
        end
        ST_WB: begin
          unique case (1'b1)
            (op == OP_ADD) || (op == OP_SUB): begin
              flags <= {alu_cout, alu_z, alu_n};
            end
            (op == OP_EQ): begin
              flags[FLAG_Z] <= alu_z;
              flags[FLAG_N] <= alu_n;
            end
            default: ;
          endcase
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed + randomized bench for alu_ctrl_unit with a behavioural
// ALU and an architectural register/flag model.
module tb_alu_ctrl_unit;

  localparam logic [5:0] T_NOP = 6'b000000;
  localparam logic [5:0] T_LDI = 6'b000001;
  localparam logic [5:0] T_ADD = 6'b010000;
  localparam logic [5:0] T_SUB = 6'b010001;
  localparam logic [5:0] T_EQ  = 6'b100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_op;
  logic        alu_cin;
  logic [31:0] alu_ans;
  logic        alu_cout, alu_z, alu_n;
  logic [2:0]  flags;
  logic        done, illegal;
  logic [3:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [16];
  logic        mc, mz, mn;

  always #5 clk = ~clk;

  alu_ctrl_unit #(.NREGS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_ans    (alu_ans),
    .alu_cout   (alu_cout),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .flags      (flags),
    .done       (done),
    .illegal    (illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // {cout, z, n, ans}
  function automatic logic [34:0] alu_fn(input logic [5:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [32:0] r;
    case (op)
      T_ADD:   r = {1'b0, a} + {1'b0, b} + 33'(cin);
      T_SUB:   r = {1'b0, a} - {1'b0, b} - 33'(cin);
      T_EQ:    r = {32'b0, (a == b)};
      default: r = {1'b0, a ^ b};
    endcase
    return {r[32], (r[31:0] == 32'b0), r[31], r[31:0]};
  endfunction

  always_comb begin
    {alu_cout, alu_z, alu_n, alu_ans} = alu_fn(alu_op, alu_a, alu_b, alu_cin);
  end

  function automatic logic legal(input logic [5:0] op);
    return op inside {T_NOP, T_LDI, T_ADD, T_SUB, T_EQ};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] rd,
      input logic [3:0] rs1, input logic [3:0] rs2, input logic uc);
    logic [12:0] junk;
    junk = 13'($urandom);
    return {op, rd, rs1, rs2, uc, junk};
  endfunction

  function automatic logic [31:0] mk_ldi(input logic [3:0] rd, input logic [17:0] imm);
    logic [3:0] junk;
    junk = 4'($urandom);
    return {T_LDI, rd, junk, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    {mc, mz, mn} = 3'b000;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      dbg_addr = 4'(i);
      #1;
      chk(tag, dbg_data, mregs[i]);
    end
  endtask

  task automatic issue(input logic [31:0] ins);
    logic [5:0]  op;
    logic [3:0]  rd, rs1, rs2;
    logic [31:0] ea, eb;
    logic        ecin;
    logic [34:0] r;
    int          n;
    op  = ins[31:26];
    rd  = ins[25:22];
    rs1 = ins[21:18];
    rs2 = ins[17:14];
    n = 0;
    while (instr_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("ready_t0", instr_ready, 1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr = $urandom;
    instr_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("illegal_t1", illegal, !legal(op));
    chk("ready_t1", instr_ready, 0);
    chk("done_t1", done, 0);
    if (!legal(op)) begin
      instr_valid = 1'b0;
      @(negedge clk);
      chk("ready_t2_ill", instr_ready, 1);
      chk("illegal_t2", illegal, 0);
      chk("flags_ill", flags, {mc, mz, mn});
      return;
    end
    ea = mregs[rs1];
    eb = mregs[rs2];
    ecin = 1'b0;
`ifdef CU_CARRY_CHAIN_EN
    if ((op == T_ADD || op == T_SUB) && ins[13]) ecin = mc;
`endif
    @(negedge clk);
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_op", alu_op, op);
    chk("alu_cin", alu_cin, ecin);
    chk("done_t2", done, 0);
    @(negedge clk);
    chk("done_t3", done, 1);
    chk("ready_t3", instr_ready, 0);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("done_t4", done, 0);
    chk("ready_t4", instr_ready, 1);
    r = alu_fn(op, ea, eb, ecin);
    case (op)
      T_ADD, T_SUB: begin
        if (rd != 0) mregs[rd] = r[31:0];
        {mc, mz, mn} = r[34:32];
      end
      T_EQ: begin
        if (rd != 0) mregs[rd] = r[31:0];
        mz = r[33];
        mn = r[32];
      end
      T_LDI: if (rd != 0) mregs[rd] = {14'b0, ins[17:0]};
      default: ;
    endcase
    dbg_addr = rd;
    #1;
    chk("dbg_rd", dbg_data, mregs[rd]);
    chk("flags", flags, {mc, mz, mn});
  endtask

  initial begin
    logic [5:0] rop;
    model_reset();
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_flags", flags, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_cin", alu_cin, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sweep("rst_regs");

    issue(mk_ldi(4'd1, 18'd5));
    issue(mk_ldi(4'd2, 18'd7));
    issue(mk(T_ADD, 4'd3, 4'd1, 4'd2, 1'b0));
    chk("add_r3", dbg_data, 32'd12);
    chk("add_flags", flags, 3'b000);

    issue(mk(T_SUB, 4'd4, 4'd1, 4'd1, 1'b0));
    chk("sub_r4", dbg_data, 32'd0);
    chk("sub_flags", flags, 3'b010);

    issue(mk(6'b110000, 4'd1, 4'd2, 4'd3, 1'b0));
    sweep("ill_regs");

    issue(mk_ldi(4'd0, 18'h3FFFF));
    chk("r0_zero", dbg_data, 32'd0);

    issue(mk_ldi(4'd6, 18'h3FFFF));
    for (int i = 0; i < 14; i++) issue(mk(T_ADD, 4'd6, 4'd6, 4'd6, 1'b0));
    issue(mk(T_ADD, 4'd7, 4'd6, 4'd6, 1'b0));
    chk("carry_set", flags[2], 1);
    issue(mk(T_ADD, 4'd8, 4'd1, 4'd2, 1'b1));

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: issue(mk(T_NOP, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom)));
        1: issue(mk_ldi(4'($urandom), 18'($urandom)));
        2: issue(mk(T_ADD, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom)));
        3: issue(mk(T_SUB, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom)));
        4: issue(mk(T_EQ, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom)));
        default: begin
          rop = 6'($urandom);
          while (legal(rop)) rop = 6'($urandom);
          issue(mk(rop, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom)));
        end
      endcase
    end
    sweep("rand_regs");

    issue(mk_ldi(4'd1, 18'd9));
    @(negedge clk);
    instr = mk(T_ADD, 4'd5, 4'd1, 4'd1, 1'b0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_flags", flags, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_ready2", instr_ready, 1);
    chk("midrst_done2", done, 0);
    dbg_addr = 4'd5;
    #1;
    chk("midrst_r5", dbg_data, 0);
    sweep("midrst_regs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
